// File: rtl/ws2811_rx_pkg.sv
// rtl/ws2811_rx_pkg.sv - shared WS2811 timing constants, log2 helper and receiver state type
package ws2811_rx_pkg;

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW, S_ERROR} state_t;

  localparam int BITS_PER_PIXEL = 24;

  function automatic int log2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Timing is derived from the clock so transmitter and receiver agree on bit widths.
  function automatic int ws_cycle(input int sysclk);
    return sysclk / 400000;
  endfunction

  function automatic int ws_t1_min(input int sysclk);
    return ws_cycle(sysclk) * 35 / 100;
  endfunction

  function automatic int ws_hmin(input int sysclk);
    return ws_cycle(sysclk) / 10;
  endfunction

  function automatic int ws_hmax(input int sysclk);
    return ws_cycle(sysclk) * 75 / 100;
  endfunction

  function automatic int ws_gap(input int sysclk);
    return 20 * ws_cycle(sysclk);
  endfunction

endpackage

// File: rtl/ws2811_rx_if.sv
// rtl/ws2811_rx_if.sv - decoded pixel / frame status bundle of the WS2811 receiver
interface ws2811_rx_if #(parameter int ADDR_W = 2);
  logic              pixel_valid;
  logic [ADDR_W-1:0] address;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;
  logic              frame_done;
  logic              bit_error;
  logic              overflow;

  modport master (
    output pixel_valid, address, red_out, green_out, blue_out,
    output frame_done, bit_error, overflow
  );

  modport slave (
    input pixel_valid, address, red_out, green_out, blue_out,
    input frame_done, bit_error, overflow
  );
endinterface

// File: rtl/ws2811_rx_sync2.sv
// rtl/ws2811_rx_sync2.sv - two-flop synchronizer for the asynchronous serial line
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ws2811_rx.sv
// rtl/ws2811_rx.sv - WS2811 serial pixel receiver: pulse-width bit decode, pixel assembly, gap framing
module ws2811_rx
  import ws2811_rx_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 100_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         DI,
  ws2811_rx_if.master  px
);
  localparam int T1_MIN = ws_t1_min(SYSTEM_CLOCK);
  localparam int HMIN   = ws_hmin(SYSTEM_CLOCK);
  localparam int HMAX   = ws_hmax(SYSTEM_CLOCK);
  localparam int GAP    = ws_gap(SYSTEM_CLOCK);
  localparam int CNT_W  = $clog2(GAP + 1);
  localparam int ADDR_W = log2_min1(NUM_LEDS);
  localparam int PIX_W  = $clog2(NUM_LEDS + 1);

  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] T1_C   = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] HMIN_C = CNT_W'(HMIN);
  localparam logic [CNT_W-1:0] HMAX_C = CNT_W'(HMAX);
  localparam logic [PIX_W-1:0] LEDS_C = PIX_W'(NUM_LEDS);

  logic             ds, ds_prev, rise;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             shift_en, bit_val, hi_err, gap_evt, hold_idle;
  logic [4:0]       bit_idx;
  logic [PIX_W-1:0] pix_cnt;
  logic [22:0]      shreg;
  logic [23:0]      pix_word;

  sync2 u_sync (.clk(clk), .reset(reset), .d(DI), .q(ds));

  always_ff @(posedge clk) begin
    if (reset) ds_prev <= 1'b0;
    else       ds_prev <= ds;
  end

  assign rise     = ds & ~ds_prev;
  assign cnt_inc  = (cnt == GAP_C) ? cnt : cnt + CNT_W'(1);
  assign pix_word = {shreg, bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One counter serves high-width and low-gap measurement; every entry into a measured phase counts its first cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_SYNC, S_ERROR: begin
        if (ds) cnt_n = '0;
        else if (cnt_inc == GAP_C) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else cnt_n = cnt_inc;
      end
      S_IDLE: begin
        cnt_n = '0;
        if (rise) begin
          cnt_n   = CNT_W'(1);
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (ds) begin
          if (cnt_inc > HMAX_C) begin
            cnt_n   = '0;
            state_n = S_ERROR;
          end else cnt_n = cnt_inc;
        end else if (cnt < HMIN_C) begin
          cnt_n   = '0;
          state_n = S_ERROR;
        end else begin
          cnt_n   = CNT_W'(1);
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (ds) begin
          cnt_n   = CNT_W'(1);
          state_n = S_HIGH;
        end else if (cnt_inc == GAP_C) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else cnt_n = cnt_inc;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_SYNC;
      end
    endcase
  end

  always_comb begin
    shift_en  = (state == S_HIGH) && !ds && (cnt >= HMIN_C);
    bit_val   = (cnt >= T1_C);
    hi_err    = (state == S_HIGH) && (ds ? (cnt_inc > HMAX_C) : (cnt < HMIN_C));
    gap_evt   = (state == S_LOW) && !ds && (cnt_inc == GAP_C);
    hold_idle = (state == S_SYNC) || (state == S_IDLE) || (state == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx        <= '0;
      pix_cnt        <= '0;
      shreg          <= '0;
      px.pixel_valid <= 1'b0;
      px.address     <= '0;
      px.red_out     <= '0;
      px.green_out   <= '0;
      px.blue_out    <= '0;
      px.frame_done  <= 1'b0;
      px.bit_error   <= 1'b0;
      px.overflow    <= 1'b0;
    end else begin
      px.pixel_valid <= 1'b0;
      px.frame_done  <= 1'b0;
      px.bit_error   <= 1'b0;
      if (hold_idle) begin
        bit_idx <= '0;
        pix_cnt <= '0;
      end
      if (hi_err) begin
        px.bit_error <= 1'b1;
        bit_idx      <= '0;
      end
      if (shift_en) begin
        shreg <= {shreg[21:0], bit_val};
        if (bit_idx == 5'(BITS_PER_PIXEL - 1)) begin
          bit_idx <= '0;
          // Surplus pixels are dropped; the index sticks at NUM_LEDS instead of wrapping.
          if (pix_cnt < LEDS_C) begin
            px.pixel_valid <= 1'b1;
            px.address     <= pix_cnt[ADDR_W-1:0];
            px.red_out     <= pix_word[23:16];
            px.green_out   <= pix_word[15:8];
            px.blue_out    <= pix_word[7:0];
            pix_cnt        <= pix_cnt + PIX_W'(1);
          end else begin
            px.overflow <= 1'b1;
          end
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end
      if (gap_evt) begin
        px.frame_done <= 1'b1;
        px.bit_error  <= (bit_idx != '0);
        bit_idx       <= '0;
        pix_cnt       <= '0;
        px.overflow   <= 1'b0;
      end
    end
  end
endmodule
